// File: rtl/nic_pkg.sv
// Shared constants for the network interface controller: PE register map
// and packet field positions.
package nic_pkg;

  localparam int DATA_WIDTH = 64;
  localparam int ADDR_WIDTH = 2;

  localparam logic [ADDR_WIDTH-1:0] ADDR_IBUF  = 2'b00;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ISTAT = 2'b01;
  localparam logic [ADDR_WIDTH-1:0] ADDR_OBUF  = 2'b10;
  localparam logic [ADDR_WIDTH-1:0] ADDR_OSTAT = 2'b11;

  localparam int VC_BIT   = 63;
  localparam int DIR_MSB  = 62;
  localparam int DIR_LSB  = 61;
  localparam int HOP_MSB  = 55;
  localparam int HOP_LSB  = 48;
  localparam int SRC_MSB  = 47;
  localparam int SRC_LSB  = 32;
  localparam int DATA_MSB = 31;
  localparam int DATA_LSB = 0;

endpackage

// File: rtl/nic_if.sv
// PE register port plus router-side channel signals of the NIC.
// slave = the NIC itself; master = the PE and router driving it.
interface nic_if;
  import nic_pkg::*;

  // PE side
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] d_in;
  logic [DATA_WIDTH-1:0] d_out;
  logic                  nicEn;
  logic                  nicWrEn;

  // Router side. Both directions follow valid/ready: a packet moves on a
  // rising edge where the sender's strobe (so/si) and the receiver's
  // ready (ro/ri) are both high; data must be stable while the strobe is high.
  logic                  net_so;
  logic                  net_ro;
  logic [DATA_WIDTH-1:0] net_do;
  logic                  net_polarity;
  logic                  net_si;
  logic                  net_ri;
  logic [DATA_WIDTH-1:0] net_di;

  modport slave (
    input  addr, d_in, nicEn, nicWrEn,
    output d_out,
    output net_so, net_do,
    input  net_ro, net_polarity,
    input  net_si, net_di,
    output net_ri
  );

  modport master (
    output addr, d_in, nicEn, nicWrEn,
    input  d_out,
    input  net_so, net_do,
    output net_ro, net_polarity,
    output net_si, net_di,
    input  net_ri
  );

endinterface

// File: rtl/nic_chan_buf.sv
// One-deep packet buffer with a full flag. A write is accepted only when
// empty; a read strobe clears the flag and leaves the data in place.
module nic_chan_buf #(
  parameter int W = 64
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         wr_i,
  input  logic [W-1:0] data_i,
  input  logic         rd_i,
  output logic [W-1:0] data_o,
  output logic         full_o
);

  logic [W-1:0] data_q, data_d;
  logic         full_q, full_d;

  // A write to an empty buffer wins over a same-cycle read strobe, so a
  // packet arriving while the PE polls an empty buffer is not lost.
  always_comb begin
    data_d = data_q;
    full_d = full_q;
    if (rd_i) full_d = 1'b0;
    if (wr_i && !full_q) begin
      data_d = data_i;
      full_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else begin
      data_q <= data_d;
      full_q <= full_d;
    end
  end

  assign data_o = data_q;
  assign full_o = full_q;

endmodule

// File: rtl/nic.sv
// Network interface controller: PE register port on one side, the PE port
// of a mesh router on the other, with one packet buffer per direction.
module nic
  import nic_pkg::*;
(
  input  logic clk,
  input  logic reset,
  nic_if.slave bus
);

  logic                  pe_wr, pe_rd;
  logic                  ocb_full, icb_full;
  logic [DATA_WIDTH-1:0] ocb_data, icb_data;
  logic [DATA_WIDTH-1:0] d_out_q, d_out_d;
  logic                  so;

  assign pe_wr = bus.nicEn & bus.nicWrEn;
  assign pe_rd = bus.nicEn & ~bus.nicWrEn;

  // Inject only when the packet's VC matches the router's current phase.
  assign so = ocb_full & bus.net_ro & (ocb_data[VC_BIT] == bus.net_polarity);

  nic_chan_buf #(.W(DATA_WIDTH)) u_ocb (
    .clk_i  (clk),
    .rst_ni (reset),
    .wr_i   (pe_wr && (bus.addr == ADDR_OBUF)),
    .data_i (bus.d_in),
    .rd_i   (so),
    .data_o (ocb_data),
    .full_o (ocb_full)
  );

  nic_chan_buf #(.W(DATA_WIDTH)) u_icb (
    .clk_i  (clk),
    .rst_ni (reset),
    .wr_i   (bus.net_si),
    .data_i (bus.net_di),
    .rd_i   (pe_rd && (bus.addr == ADDR_IBUF)),
    .data_o (icb_data),
    .full_o (icb_full)
  );

  always_comb begin
    d_out_d = d_out_q;
    if (pe_rd) begin
      unique case (bus.addr)
        ADDR_IBUF:  d_out_d = icb_data;
        ADDR_ISTAT: d_out_d = {{(DATA_WIDTH-1){1'b0}}, icb_full};
        ADDR_OBUF:  d_out_d = ocb_data;
        ADDR_OSTAT: d_out_d = {{(DATA_WIDTH-1){1'b0}}, ocb_full};
        default:    d_out_d = d_out_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) d_out_q <= '0;
    else        d_out_q <= d_out_d;
  end

  assign bus.d_out  = d_out_q;
  assign bus.net_so = so;
  assign bus.net_do = ocb_data;
  assign bus.net_ri = ~icb_full;

endmodule

// File: tb/tb_nic.sv
// Directed bench for the NIC: PE register accesses and router handshakes,
// with PE read data checked by a scoreboard monitor.
module tb_nic;
  import nic_pkg::*;

  logic clk;
  logic reset;
  nic_if bus();

  nic dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests;
  int failed;
  logic [DATA_WIDTH-1:0] exp_q[$];
  logic [ADDR_WIDTH-1:0] addr_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: a read accepted at a rising edge presents d_out just after it.
  initial begin
    logic fire;
    logic [DATA_WIDTH-1:0] e;
    logic [ADDR_WIDTH-1:0] a;
    forever begin
      @(posedge clk);
      fire = reset && bus.nicEn && !bus.nicWrEn;
      #1;
      if (fire) begin
        if (exp_q.size() == 0) begin
          tests++;
          failed++;
          $display("FAIL pe_read: got %h expected none (t=%0t)", bus.d_out, $time);
        end else begin
          e = exp_q.pop_front();
          a = addr_q.pop_front();
          check($sformatf("pe_read addr=%b", a), bus.d_out, e);
        end
      end
    end
  end

  // ---------------- drivers (called at a falling edge) ----------------
  task automatic pe_write(input logic [1:0] a, input logic [63:0] d);
    bus.addr = a; bus.d_in = d; bus.nicEn = 1'b1; bus.nicWrEn = 1'b1;
    @(negedge clk);
    bus.nicEn = 1'b0; bus.nicWrEn = 1'b0;
  endtask

  task automatic pe_read(input logic [1:0] a, input logic [63:0] exp);
    exp_q.push_back(exp);
    addr_q.push_back(a);
    bus.addr = a; bus.nicEn = 1'b1; bus.nicWrEn = 1'b0;
    @(negedge clk);
    bus.nicEn = 1'b0;
  endtask

  task automatic router_send(input logic [63:0] d);
    bus.net_si = 1'b1; bus.net_di = d;
    @(negedge clk);
    bus.net_si = 1'b0;
  endtask

  localparam logic [63:0] PKT_A    = 64'hC010_0000_1111_1111;
  localparam logic [63:0] PKT_DROP = 64'hA001_0000_2222_2222;
  localparam logic [63:0] PKT_R1   = 64'h8010_0000_4444_4444;
  localparam logic [63:0] PKT_R2   = 64'h8010_0000_5555_5555;
  localparam logic [63:0] PKT_R3   = 64'h8010_0000_6666_6666;

  // ---------------- stimulus ----------------
  initial begin
    tests = 0; failed = 0;
    reset = 1'b0;
    bus.addr = '0; bus.d_in = '0; bus.nicEn = 1'b0; bus.nicWrEn = 1'b0;
    bus.net_ro = 1'b0; bus.net_polarity = 1'b0;
    bus.net_si = 1'b0; bus.net_di = '0;

    // 1. reset state
    #2;
    check("reset net_ri", {63'b0, bus.net_ri}, 64'd1);
    check("reset net_so", {63'b0, bus.net_so}, 64'd0);
    check("reset net_do", bus.net_do, 64'd0);
    check("reset d_out", bus.d_out, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    pe_read(ADDR_ISTAT, 64'd0);
    pe_read(ADDR_OSTAT, 64'd0);
    // writes to non-OBUF addresses have no effect
    pe_write(ADDR_IBUF, '1);
    pe_write(ADDR_OSTAT, '1);
    pe_write(ADDR_ISTAT, '1);
    pe_read(ADDR_OSTAT, 64'd0);
    pe_read(ADDR_ISTAT, 64'd0);
    pe_read(ADDR_IBUF, 64'd0);
    check("idle net_so", {63'b0, bus.net_so}, 64'd0);

    // 2. injection gated by polarity, single-cycle handshake
    bus.net_ro = 1'b1;
    bus.net_polarity = 1'b0;
    pe_write(ADDR_OBUF, PKT_A);
    check("polarity mismatch net_so", {63'b0, bus.net_so}, 64'd0);
    pe_read(ADDR_OSTAT, 64'd1);
    check("polarity mismatch hold", {63'b0, bus.net_so}, 64'd0);
    bus.net_polarity = 1'b1;
    #1;
    check("inject net_so", {63'b0, bus.net_so}, 64'd1);
    check("inject net_do", bus.net_do, PKT_A);
    @(negedge clk);
    check("after inject net_so", {63'b0, bus.net_so}, 64'd0);
    check("after inject net_do retained", bus.net_do, PKT_A);
    pe_read(ADDR_OSTAT, 64'd0);

    // 3. write while full is dropped
    bus.net_ro = 1'b0;
    pe_write(ADDR_OBUF, PKT_A);
    check("ro low net_so", {63'b0, bus.net_so}, 64'd0);
    pe_write(ADDR_OBUF, PKT_DROP);
    pe_read(ADDR_OBUF, PKT_A);
    pe_read(ADDR_OSTAT, 64'd1);

    // 4. receive and PE drain
    check("rx ready before", {63'b0, bus.net_ri}, 64'd1);
    router_send(PKT_R1);
    check("rx ready after capture", {63'b0, bus.net_ri}, 64'd0);
    pe_read(ADDR_ISTAT, 64'd1);
    pe_read(ADDR_IBUF, PKT_R1);
    check("rx ready after drain", {63'b0, bus.net_ri}, 64'd1);
    pe_read(ADDR_ISTAT, 64'd0);

    // 5. send while full is ignored; empty read returns stale data
    router_send(PKT_R1);
    router_send(PKT_R2);
    pe_read(ADDR_ISTAT, 64'd1);
    pe_read(ADDR_IBUF, PKT_R1);
    pe_read(ADDR_IBUF, PKT_R1);
    pe_read(ADDR_ISTAT, 64'd0);

    // 6. asynchronous reset with both buffers full and injection pending
    router_send(PKT_R3);
    bus.net_ro = 1'b1;
    #1;
    check("pre-reset net_so", {63'b0, bus.net_so}, 64'd1);
    #1;
    reset = 1'b0;
    #1;
    check("async reset net_so", {63'b0, bus.net_so}, 64'd0);
    check("async reset net_ri", {63'b0, bus.net_ri}, 64'd1);
    check("async reset net_do", bus.net_do, 64'd0);
    @(negedge clk);
    bus.net_ro = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    pe_read(ADDR_ISTAT, 64'd0);
    pe_read(ADDR_OSTAT, 64'd0);
    pe_read(ADDR_IBUF, 64'd0);
    pe_read(ADDR_OBUF, 64'd0);

    repeat (3) @(negedge clk);
    check("scoreboard drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/nic.md
Name: nic

Overview:
- Network interface controller between a processing element (PE) and the PE port of one mesh `router`.
- Holds one 64-bit output channel buffer (PE→router) and one 64-bit input channel buffer (router→PE).
- The PE accesses both buffers and their status through a 2-bit register-mapped port.
- Injection into the router is gated by the router's `ro` handshake and by `polarity`, so a packet enters only when its VC bit matches the router's current phase.

Parameters:
- DATA_WIDTH, 64, packet width; packet format is {vc[63], dir[62:61], rsv[60:56], hop[55:48], src[47:32], data[31:0]}.
- ADDR_WIDTH, 2, width of the PE register address.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- addr  in  2  PE register select: 00 = input buffer, 01 = input status, 10 = output buffer, 11 = output status.
- d_in  in  64  PE write data.
- d_out  out  64  PE read data, registered.
- nicEn  in  1  PE access enable.
- nicWrEn  in  1  1 = write, 0 = read; qualified by nicEn.
- net_so  out  1  send to router; drives the router's pesi.
- net_ro  in  1  router ready; from the router's peri.
- net_do  out  64  packet to router; drives pedi.
- net_polarity  in  1  router polarity.
- net_si  in  1  router sends to NIC; from peso.
- net_ri  out  1  NIC ready to accept; drives pero.
- net_di  in  64  packet from router; from pedo.

Behaviour:
- Reset (reset=0, async): d_out=0, both buffers=0, ocb_full=0, icb_full=0. Consequently net_so=0, net_do=0, net_ri=1.
- PE write, addr 10 (nicEn & nicWrEn):
  - If ocb_full=0 at the edge: ocb<=d_in, ocb_full<=1.
  - If ocb_full=1: write is dropped and ocb is unchanged.
- PE writes to addr 00, 01 and 11 are ignored.
- Injection, combinational: net_so = ocb_full & net_ro & (ocb[63]==net_polarity). net_do = ocb at all times.
  - At an edge where net_so=1, ocb_full<=0 and the data in ocb is retained.
  - One packet per handshake; back-to-back injection needs a new PE write.
- Injection and PE write in the same cycle: the write sees ocb_full=1 before the edge and is dropped. The PE must poll status before writing.
- Receive: net_ri = ~icb_full, combinational.
  - At an edge with net_si & net_ri: icb<=net_di, icb_full<=1.
  - net_si while icb_full=1 is a protocol violation by the router; the NIC ignores it and icb keeps its old packet.
- PE read (nicEn & ~nicWrEn), one-cycle latency; d_out updates at the edge:
  - addr 00: d_out<=icb. If icb_full=1, icb_full<=0. Reading while empty returns stale icb and changes no flag.
  - addr 01: d_out<={63'b0, icb_full}.
  - addr 10: d_out<=ocb; no side effect.
  - addr 11: d_out<={63'b0, ocb_full}.
  - d_out holds its value in every cycle without a read.
- PE read of addr 00 and router send in the same cycle: cannot coincide on a full buffer, because net_ri=0. If the buffer is empty, the new packet is captured and the read returns stale data.
- Reset asserted mid-transfer: any packet held in either buffer is discarded, and net_so drops immediately because it is combinational on ocb_full.
- No hop or address modification; the NIC is transparent to packet contents.

Decomposition:
- Shared package `nic_pkg`:
  - Address constants ADDR_IBUF=2'b00, ADDR_ISTAT=2'b01, ADDR_OBUF=2'b10, ADDR_OSTAT=2'b11.
  - Packet field indices VC_BIT=63, DIR_MSB/LSB=62/61, HOP_MSB/LSB=55/48, SRC_MSB/LSB=47/32, DATA_MSB/LSB=31/0.
- One sub-module `nic_chan_buf`: a 1-deep register with full flag, wr/rd strobes and async active-low reset. It is instantiated twice, for icb and ocb.

Test Plan:
1. Reset, then read addr 01 and addr 11 → d_out=0 for both. net_ri=1, net_so=0.
2. Write addr 10 with 64'hC010_0000_1111_1111 (vc=1), net_ro=1:
   - While polarity=0: net_so=0.
   - When polarity=1: net_so=1 for exactly one cycle with net_do=64'hC010_0000_1111_1111.
   - Next read of addr 11 returns 0.
3. With ocb full and net_ro=0, write 64'hA001_0000_2222_2222 → dropped. Read addr 10 still returns 64'hC010_0000_1111_1111, and addr 11 returns 1.
4. Router drives net_si=1 with net_di=64'h8010_0000_4444_4444:
   - net_ri goes to 0 the next cycle, and read addr 01 returns 1.
   - Read addr 00 returns 64'h8010_0000_4444_4444, then read addr 01 returns 0 and net_ri=1.
5. Second net_si with 64'h...5555_5555 while icb is full → ignored. Read addr 00 returns the 4444_4444 packet.
6. Assert reset low mid-cycle while ocb is full and polarity matches → net_so falls asynchronously, and all status reads return 0 after release.
